// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters, one transaction outstanding: combinational grant,
// memReq next cycle, valid one cycle after memAck; requesters hold Req until Gnt. Bus timeout under MEM_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int DATA_BURST_MAX = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        flush,
  input  logic        ifReq,
  input  logic [31:0] ifAddr,
  output logic        ifGnt,
  output logic        ifValid,
  output logic [31:0] ifData,
  output logic        ifErr,
  input  logic        dReq,
  input  logic        dWe,
  input  logic [1:0]  dSize,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWData,
  output logic        dGnt,
  output logic        dValid,
  output logic [31:0] dRData,
  output logic        dErr,
  output logic        memReq,
  output logic        memWe,
  output logic [1:0]  memSize,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic        memAck,
  input  logic [31:0] memRData,
  output logic        busError
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
`ifdef MEM_TIMEOUT_EN
    , TOERR
`endif
  } state_t;

  state_t     state;
  logic [3:0] burst_cnt;
  logic       suppress;
  logic       if_err_q;
  logic       d_err_q;
  logic       arb_ok;
  logic       fetch_win;
  logic       data_win;
  logic       if_mis;
  logic       d_mis;

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            bus_err_q;
  assign busError = bus_err_q;
`else
  assign busError = 1'b0;
`endif

  // Grants are decided combinationally so the Gnt pulse lands in the same cycle the fields are sampled.
  assign arb_ok    = (state == IDLE) && enable && !reset;
  assign fetch_win = arb_ok && ifReq && !flush &&
                     (!dReq || burst_cnt == 4'(DATA_BURST_MAX));
  assign data_win  = arb_ok && dReq && !fetch_win;
  assign if_mis    = ifAddr[1:0] != 2'b00;

  always_comb begin
    d_mis = 1'b0;
    case (dSize)
      2'b00:   d_mis = 1'b0;
      2'b01:   d_mis = dAddr[0];
      2'b10:   d_mis = dAddr[1:0] != 2'b00;
      default: d_mis = 1'b1;
    endcase
  end

  assign ifGnt = fetch_win;
  assign dGnt  = data_win;
  assign ifErr = (fetch_win && if_mis) || if_err_q;
  assign dErr  = (data_win && d_mis) || d_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      burst_cnt <= 4'd0;
      suppress  <= 1'b0;
      if_err_q  <= 1'b0;
      d_err_q   <= 1'b0;
      ifValid   <= 1'b0;
      ifData    <= 32'h0;
      dValid    <= 1'b0;
      dRData    <= 32'h0;
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memSize   <= 2'b00;
      memAddr   <= 32'h0;
      memWData  <= 32'h0;
`ifdef MEM_TIMEOUT_EN
      to_cnt    <= '0;
      bus_err_q <= 1'b0;
`endif
    end else begin
      ifValid  <= 1'b0;
      dValid   <= 1'b0;
      if_err_q <= 1'b0;
      d_err_q  <= 1'b0;

      if (fetch_win)
        burst_cnt <= 4'd0;
      else if (data_win && ifReq && burst_cnt != 4'(DATA_BURST_MAX))
        burst_cnt <= burst_cnt + 4'd1;

      case (state)
        IDLE: begin
          if (fetch_win && !if_mis) begin
            state    <= FETCH;
            memReq   <= 1'b1;
            memWe    <= 1'b0;
            memSize  <= 2'b10;
            memAddr  <= ifAddr;
            memWData <= 32'h0;
            suppress <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            to_cnt   <= '0;
`endif
          end else if (data_win && !d_mis) begin
            state    <= DATA;
            memReq   <= 1'b1;
            memWe    <= dWe;
            memSize  <= dSize;
            memAddr  <= dAddr;
            memWData <= dWData;
`ifdef MEM_TIMEOUT_EN
            to_cnt   <= '0;
`endif
          end
        end

        FETCH, DATA: begin
          // A flush anywhere in the fetch window kills its valid, even if it drops before memAck.
          if (state == FETCH)
            suppress <= suppress || flush;
          if (memAck) begin
            memReq <= 1'b0;
            state  <= IDLE;
            if (state == FETCH) begin
              ifValid <= !(suppress || flush);
              if (!(suppress || flush))
                ifData <= memRData;
            end else begin
              dValid <= 1'b1;
              dRData <= memWe ? 32'h0 : memRData;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            memReq    <= 1'b0;
            bus_err_q <= 1'b1;
            state     <= TOERR;
            if (state == FETCH)
              if_err_q <= 1'b1;
            else
              d_err_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end

`ifdef MEM_TIMEOUT_EN
        TOERR: state <= IDLE;
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule
